monster_line_scheduler: RTL and testbench
=========================================

# monster_line_scheduler

Per-scanline sprite scheduler for the monster layer of the VGA pixel path. During horizontal blanking it scans the 12-entry monster state vector and builds a slot table of up to SLOTS monsters that intersect the next background row. During active video it arbitrates the single shared monster ROM address port among those slots for each pixel. It replaces the per-pixel 12-way comparison with a sequenced, double-buffered lookup.

## Interface
- MONSTERS, 12, entries in state_monsters (19 bits each)
- SLOTS, 4, max monsters drawn per background row
- MONS_W, 20, monster sprite width in bg pixels
- MONS_H, 21, monster sprite height in bg rows
- clk_vga  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- line_start  in  1  one-cycle pulse, issued by sync generator early in hblank
- y_next  in  8  background row (y_ptr/2) of the line about to be drawn; sampled with line_start
- state_monsters  in  228  entry i = bits [19i+18:19i]: [0] alive, [2:1] dir (00 up, 01 down, 10 left, 11 right), [10:3] x, [18:11] y
- x_bg  in  8  current background column
- x_valid  in  1  pixel is inside background window (bg_on)
- addr_monster  out  9  monster ROM address, row*20 + column
- dir_on  out  4  one-hot {right,left,down,up}; 0 = no monster at pixel
- monster_on  out  1  OR of dir_on
- scan_busy  out  1  scan/commit in progress
- slot_count  out  3  valid slots in active table
- overflow  out  1  more than SLOTS monsters hit the last scanned row

## Operation
- Two tables of SLOTS entries {x[7:0], dir[1:0], row[4:0]}: candidate (written by scan) and active (read by pixel path).
- FSM states IDLE, SCAN, COMMIT.
- IDLE: on line_start, latch y_next, clear candidate count and overflow flag, set idx=0, go to SCAN.
- SCAN: one entry per cycle, idx 0..MONSTERS-1. Hit = alive && y_next >= y && y_next < y+MONS_H. The compare is done in 9 bits (y+21 up to 276 must not wrap).
  - On a hit with count<SLOTS: write {x, dir, y_next-y} to slot[count] and increment count.
  - On a hit with count==SLOTS: set overflow and drop the entry.
  - After idx=MONSTERS-1, go to COMMIT.
- COMMIT: copy candidate to active, load slot_count and overflow, go to IDLE.
- line_start in SCAN or COMMIT restarts the scan: relatch y_next, clear the candidate, idx=0. The active table is unchanged until the next COMMIT completes.
- Pixel path: slot s is valid when s<slot_count. Slot s matches when x_valid && x_bg >= x_s && x_bg < x_s+MONS_W (9-bit compare).
  - The lowest matching slot wins, so the lower monster index has priority on overlap.
  - Winner: addr_monster = row*20 + (x_bg - x_s) (max 419), dir_on = onehot(dir).
  - No match or !x_valid: addr_monster=0, dir_on=0.
- state_monsters is sampled only during SCAN. Changes during active video take effect on the next line.

## Timing
- Reset (async): FSM IDLE, both tables empty, slot_count=0, overflow=0, scan_busy=0, addr_monster=0, dir_on=0, monster_on=0.
- line_start sampled at edge T: SCAN spans T+1..T+12, COMMIT at T+13. scan_busy is high for cycles T+1..T+13.
- The new active table and slot_count are visible from T+14. Worst-case hblank budget is 14 clk_vga, well inside the 160-cycle hblank.
- Pixel path is registered with 1-cycle latency: x_bg at edge P gives addr_monster/dir_on valid after edge P+1. The consumer delays bg and hero data by one cycle to align.
- ROM read data follows addr_monster by the ROM's own latency; that alignment is the consumer's concern.
- line_start while IDLE and simultaneously with COMMIT: COMMIT completes (active updated), then the new scan starts the next cycle.

## Test plan
- Reset mid-scan: assert rst at T+5 after line_start -> all outputs 0 immediately; slot_count=0 after release; no commit occurs.
- Single monster: entry 3 alive, x=40, y=100, dir=10; line_start with y_next=105 -> slot_count=1 at T+14. x_bg=45 gives addr_monster=105 and dir_on=0100 one cycle later. x_bg=60 gives dir_on=0.
- Row boundaries: monster y=100; y_next=99 -> slot_count=0; y_next=100 -> row 0; y_next=120 -> row 20 (addr at x offset 0 = 400); y_next=121 -> slot_count=0. Also y=250 with y_next=255 -> hit with no wrap.
- Overflow: 6 alive monsters all covering y_next=50, indices 0..5 -> slot_count=4, overflow=1, slots hold indices 0..3; indices 4 and 5 are never drawn.
- Overlap priority: entries 1 and 7 both at x=30 on the line, dirs 00 and 11 -> at x_bg=35 dir_on=0001 (entry 1 wins).
- Restart: second line_start at T+6 with a different y_next -> scan_busy stays high until the second scan's COMMIT; the active table reflects only the second y_next.

Source files
------------

// File: rtl/monster_line_scheduler.sv
// Per-scanline monster scheduler: scans 12 monsters in hblank into a SLOTS-entry table,
// then picks the lowest matching slot per pixel to drive the shared monster ROM address.
module monster_line_scheduler #(
  parameter int MONSTERS = 12,
  parameter int SLOTS    = 4,
  parameter int MONS_W   = 20,
  parameter int MONS_H   = 21
) (
  input  logic                    clk_vga,
  input  logic                    rst,
  input  logic                    line_start,
  input  logic [7:0]              y_next,
  input  logic [19*MONSTERS-1:0]  state_monsters,
  input  logic [7:0]              x_bg,
  input  logic                    x_valid,
  output logic [8:0]              addr_monster,
  output logic [3:0]              dir_on,
  output logic                    monster_on,
  output logic                    scan_busy,
  output logic [2:0]              slot_count,
  output logic                    overflow
);

  typedef struct packed {
    logic [7:0] x;
    logic [1:0] dir;
    logic [4:0] row;
  } slot_t;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t      state, state_nxt;
  logic        scan_start, do_commit;
  logic [3:0]  idx;
  logic [7:0]  y_lat;
  logic [2:0]  cand_cnt;
  logic        cand_ovf;
  slot_t       cand [SLOTS];
  slot_t       act  [SLOTS];

  logic [18:0] ent;
  logic [7:0]  ent_y;
  logic [7:0]  dy;
  logic        hit;

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // line_start always wins over the scan sequence; in COMMIT the copy still happens.
  always_comb begin
    state_nxt  = state;
    scan_start = 1'b0;
    do_commit  = 1'b0;
    case (state)
      IDLE: begin
        if (line_start) begin
          scan_start = 1'b1;
          state_nxt  = SCAN;
        end
      end
      SCAN: begin
        if (line_start)                     scan_start = 1'b1;
        else if (idx == 4'(MONSTERS - 1))   state_nxt  = COMMIT;
      end
      COMMIT: begin
        do_commit = 1'b1;
        if (line_start) begin
          scan_start = 1'b1;
          state_nxt  = SCAN;
        end else begin
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ent = '0;
    for (int i = 0; i < MONSTERS; i++)
      if (idx == 4'(i)) ent = state_monsters[19*i +: 19];
  end

  // 9-bit compare so y+MONS_H near the bottom of the screen cannot wrap.
  assign ent_y = ent[18:11];
  assign dy    = y_lat - ent_y;
  assign hit   = ent[0] && ({1'b0, y_lat} >= {1'b0, ent_y}) &&
                 ({1'b0, y_lat} < ({1'b0, ent_y} + 9'(MONS_H)));

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      y_lat      <= '0;
      idx        <= '0;
      cand_cnt   <= '0;
      cand_ovf   <= 1'b0;
      slot_count <= '0;
      overflow   <= 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        cand[s] <= '0;
        act[s]  <= '0;
      end
    end else begin
      if (do_commit) begin
        act        <= cand;
        slot_count <= cand_cnt;
        overflow   <= cand_ovf;
      end
      if (scan_start) begin
        y_lat    <= y_next;
        idx      <= '0;
        cand_cnt <= '0;
        cand_ovf <= 1'b0;
      end else if (state == SCAN) begin
        idx <= idx + 4'd1;
        if (hit) begin
          if (cand_cnt < 3'(SLOTS)) begin
            for (int s = 0; s < SLOTS; s++)
              if (cand_cnt == 3'(s)) cand[s] <= '{x: ent[10:3], dir: ent[2:1], row: dy[4:0]};
            cand_cnt <= cand_cnt + 3'd1;
          end else begin
            cand_ovf <= 1'b1;
          end
        end
      end
    end
  end

  assign scan_busy = (state != IDLE);

  logic [7:0] x_off [SLOTS];
  logic [8:0] pix_addr;
  logic [3:0] pix_dir;
  logic       found;

  always_comb begin
    for (int s = 0; s < SLOTS; s++) x_off[s] = x_bg - act[s].x;
  end

  // Lowest slot wins, which preserves monster-index priority from the scan order.
  always_comb begin
    pix_addr = '0;
    pix_dir  = '0;
    found    = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (!found && x_valid && (3'(s) < slot_count) &&
          ({1'b0, x_bg} >= {1'b0, act[s].x}) &&
          ({1'b0, x_bg} < ({1'b0, act[s].x} + 9'(MONS_W)))) begin
        found    = 1'b1;
        pix_addr = ({4'b0, act[s].row} * 9'(MONS_W)) + {1'b0, x_off[s]};
        pix_dir  = 4'b0001 << act[s].dir;
      end
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      addr_monster <= '0;
      dir_on       <= '0;
      monster_on   <= 1'b0;
    end else begin
      addr_monster <= pix_addr;
      dir_on       <= pix_dir;
      monster_on   <= |pix_dir;
    end
  end

endmodule

// File: tb/tb_monster_line_scheduler.sv
// Scoreboard bench: stimulus posts expected values, a monitor compares them one cycle later.
module tb_monster_line_scheduler;

  logic         clk_vga = 1'b0;
  logic         rst;
  logic         line_start;
  logic [7:0]   y_next;
  logic [227:0] mons;
  logic [7:0]   x_bg;
  logic         x_valid;
  logic [8:0]   addr_monster;
  logic [3:0]   dir_on;
  logic         monster_on;
  logic         scan_busy;
  logic [2:0]   slot_count;
  logic         overflow;

  monster_line_scheduler dut (
    .clk_vga(clk_vga), .rst(rst), .line_start(line_start), .y_next(y_next),
    .state_monsters(mons), .x_bg(x_bg), .x_valid(x_valid),
    .addr_monster(addr_monster), .dir_on(dir_on), .monster_on(monster_on),
    .scan_busy(scan_busy), .slot_count(slot_count), .overflow(overflow)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct {
    string name;
    int    sel;
    int    val;
  } item_t;

  item_t exp_q[$];
  int    pend    = 0;
  int    probe   = 0;
  int    probe_d = 0;
  int    n_chk   = 0;
  int    n_pass  = 0;
  int    cur_cnt = 0;

  always @(posedge clk_vga) probe_d <= probe;

  always @(negedge clk_vga) begin
    if (probe_d > 0) begin
      for (int i = 0; i < probe_d; i++) begin
        item_t it;
        int    act;
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_empty: got no expected entry, required one");
        end else begin
          it = exp_q.pop_front();
          case (it.sel)
            0:       act = int'(addr_monster);
            1:       act = int'(dir_on);
            2:       act = int'(monster_on);
            3:       act = int'(slot_count);
            4:       act = int'(overflow);
            default: act = int'(scan_busy);
          endcase
          if (act == it.val) n_pass++;
          else $display("FAIL %s: got %0d required %0d", it.name, act, it.val);
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk_vga);
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench did not finish");
  end

  task automatic post(input string nm, input int sel, input int val);
    item_t it;
    it.name = nm;
    it.sel  = sel;
    it.val  = val;
    exp_q.push_back(it);
    pend++;
  endtask

  task automatic tick();
    probe = pend;
    pend  = 0;
    @(negedge clk_vga);
    probe = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_mon(input int i, input bit alive, input bit [1:0] dir,
                         input bit [7:0] x, input bit [7:0] y);
    mons[19*i +: 19] = {y, x, dir, alive};
  endtask

  task automatic pix(input string nm, input bit [7:0] xb, input bit xv, input int a, input int d);
    x_bg    = xb;
    x_valid = xv;
    post({nm, "_addr"}, 0, a);
    post({nm, "_dir"},  1, d);
    post({nm, "_on"},   2, (d != 0) ? 1 : 0);
    tick();
  endtask

  // line_start sampled at edge T; busy right after T and T+12, table visible after T+13.
  task automatic run_line(input string nm, input bit [7:0] y, input int cnt, input int ovf);
    y_next     = y;
    line_start = 1'b1;
    post({nm, "_busy_first"}, 5, 1);
    tick();
    line_start = 1'b0;
    idle(11);
    post({nm, "_busy_last"}, 5, 1);
    post({nm, "_cnt_before_commit"}, 3, cur_cnt);
    tick();
    post({nm, "_busy_done"}, 5, 0);
    post({nm, "_cnt"}, 3, cnt);
    post({nm, "_ovf"}, 4, ovf);
    tick();
    cur_cnt = cnt;
  endtask

  initial begin
    rst        = 1'b1;
    line_start = 1'b0;
    y_next     = '0;
    mons       = '0;
    x_bg       = '0;
    x_valid    = 1'b1;
    repeat (3) @(negedge clk_vga);
    rst = 1'b0;

    post("rst_addr", 0, 0); post("rst_dir", 1, 0); post("rst_on", 2, 0);
    post("rst_cnt", 3, 0);  post("rst_ovf", 4, 0); post("rst_busy", 5, 0);
    tick();

    // Single monster, entry 3, dir left.
    set_mon(3, 1'b1, 2'b10, 8'd40, 8'd100);
    run_line("single", 8'd105, 1, 0);
    pix("single_x45", 8'd45, 1'b1, 105, 4);
    pix("single_x60", 8'd60, 1'b1, 0, 0);
    pix("single_x59", 8'd59, 1'b1, 119, 4);
    pix("single_x39", 8'd39, 1'b1, 0, 0);
    pix("single_nvld", 8'd45, 1'b0, 0, 0);

    // Row boundaries.
    mons = '0;
    set_mon(0, 1'b1, 2'b01, 8'd0, 8'd100);
    run_line("y99", 8'd99, 0, 0);
    pix("y99_x7", 8'd7, 1'b1, 0, 0);
    run_line("y100", 8'd100, 1, 0);
    pix("y100_x7", 8'd7, 1'b1, 7, 2);
    run_line("y120", 8'd120, 1, 0);
    pix("y120_x0", 8'd0, 1'b1, 400, 2);
    pix("y120_x19", 8'd19, 1'b1, 419, 2);
    run_line("y121", 8'd121, 0, 0);
    pix("y121_x0", 8'd0, 1'b1, 0, 0);
    set_mon(0, 1'b1, 2'b01, 8'd0, 8'd250);
    run_line("y255", 8'd255, 1, 0);
    pix("y255_x19", 8'd19, 1'b1, 119, 2);
    pix("y255_x20", 8'd20, 1'b1, 0, 0);

    // Overflow: six hits, only indices 0..3 kept.
    mons = '0;
    for (int i = 0; i < 6; i++) set_mon(i, 1'b1, 2'(i % 4), 8'(10 + 30 * i), 8'd40);
    run_line("ovf", 8'd50, 4, 1);
    pix("ovf_m0", 8'd13, 1'b1, 203, 1);
    pix("ovf_m2", 8'd75, 1'b1, 205, 4);
    pix("ovf_m3", 8'd119, 1'b1, 219, 8);
    pix("ovf_m4", 8'd130, 1'b1, 0, 0);
    pix("ovf_m5", 8'd160, 1'b1, 0, 0);

    // Overlap priority: entry 1 beats entry 7.
    mons = '0;
    set_mon(1, 1'b1, 2'b00, 8'd30, 8'd50);
    set_mon(7, 1'b1, 2'b11, 8'd30, 8'd50);
    run_line("prio", 8'd50, 2, 0);
    pix("prio_x35", 8'd35, 1'b1, 5, 1);
    pix("prio_x55", 8'd55, 1'b1, 0, 0);

    // Restart at T+6: first scan (two hits) must never commit.
    mons = '0;
    set_mon(0, 1'b1, 2'b00, 8'd0,   8'd10);
    set_mon(1, 1'b1, 2'b01, 8'd50,  8'd10);
    set_mon(2, 1'b1, 2'b11, 8'd100, 8'd200);
    y_next     = 8'd15;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      post("restart_busy_first_scan", 5, 1);
      tick();
    end
    run_line("restart", 8'd205, 1, 0);
    pix("restart_m2", 8'd100, 1'b1, 100, 8);
    pix("restart_m0", 8'd0, 1'b1, 0, 0);
    pix("restart_m1", 8'd55, 1'b1, 0, 0);

    // Reset mid-scan.
    pix("pre_rst_m2", 8'd105, 1'b1, 105, 8);
    y_next     = 8'd205;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    idle(4);
    rst = 1'b1;
    post("midrst_addr", 0, 0); post("midrst_dir", 1, 0); post("midrst_on", 2, 0);
    post("midrst_cnt", 3, 0);  post("midrst_ovf", 4, 0); post("midrst_busy", 5, 0);
    tick();
    rst = 1'b0;
    cur_cnt = 0;
    idle(14);
    post("postrst_cnt", 3, 0);
    post("postrst_busy", 5, 0);
    pix("postrst_m2", 8'd105, 1'b1, 0, 0);

    idle(3);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_leftover: got %0d pending entries required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
